// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Board geometry, piece codes, column/row masks, FSM state
//               encoding and the spawn-mask helper for the piece engine.
// Revision    : 1.0  initial release
// ============================================================================
package tetris_pkg;

  localparam int BOARD_W  = 32;
  localparam int ROW_W    = 4;
  localparam int NUM_ROWS = 8;

  localparam logic [1:0] PIECE_DOT    = 2'b00;
  localparam logic [1:0] PIECE_DOMINO = 2'b01;
  localparam logic [1:0] PIECE_SQUARE = 2'b10;
  localparam logic [1:0] PIECE_L      = 2'b11;

  localparam logic [BOARD_W-1:0] COL0_MASK       = 32'h1111_1111;
  localparam logic [BOARD_W-1:0] COL3_MASK       = 32'h8888_8888;
  localparam logic [BOARD_W-1:0] BOTTOM_ROW_MASK = 32'hF000_0000;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SPAWN    = 3'd1;
  localparam logic [2:0] ST_FALL     = 3'd2;
  localparam logic [2:0] ST_HANDOFF  = 3'd3;
  localparam logic [2:0] ST_WAIT_CLR = 3'd4;
  localparam logic [2:0] ST_GAMEOVER = 3'd5;

  // Every piece enters in rows 0-1, anchored on columns 1-2.
  function automatic logic [BOARD_W-1:0] spawn_mask(input logic [1:0] code);
    logic [BOARD_W-1:0] m;
    m = '0;
    case (code)
      PIECE_DOT:    m = 32'h0000_0002;
      PIECE_DOMINO: m = 32'h0000_0006;
      PIECE_SQUARE: m = 32'h0000_0066;
      PIECE_L:      m = 32'h0000_0062;
      default:      m = '0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piece_mover.sv
`default_nettype none
// ============================================================================
// Module      : piece_mover
// Description : Candidate positions of the active piece after a down, left
//               or right step, and whether each step collides with the board
//               edge or with settled cells.
// Revision    : 1.0  initial release
// ============================================================================
module piece_mover
  import tetris_pkg::*;
(
  input  logic [BOARD_W-1:0] active,
  input  logic [BOARD_W-1:0] settled,
  output logic [BOARD_W-1:0] down_next,
  output logic [BOARD_W-1:0] left_next,
  output logic [BOARD_W-1:0] right_next,
  output logic               down_blocked,
  output logic               left_blocked,
  output logic               right_blocked
);

  // Shifts are only taken when the matching edge check is clear, so a
  // blocked move never wraps into a neighbouring row.
  always_comb begin
    down_next     = active << ROW_W;
    left_next     = active >> 1;
    right_next    = active << 1;
    down_blocked  = (|(active & BOTTOM_ROW_MASK)) || (|(down_next & settled));
    left_blocked  = (|(active & COL0_MASK))       || (|(left_next & settled));
    right_blocked = (|(active & COL3_MASK))       || (|(right_next & settled));
  end

endmodule
`default_nettype wire

// File: rtl/piece_drop.sv
`default_nettype none
// ============================================================================
// Module      : piece_drop
// Description : Active-piece engine: spawns, applies gravity and lateral
//               moves, merges the landed piece, hands the merged board to the
//               clear stage and waits for the cleared board to come back.
// Revision    : 1.0  initial release
// ============================================================================
module piece_drop
  import tetris_pkg::*;
#(
  parameter int GRAV_TICKS = 8,
  parameter int CNT_W      = 8
) (
  input  logic        clka,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  curr_piece,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        drop_fast,
  output logic        lock_valid,
  output logic [31:0] lock_board,
  input  logic        lock_ready,
  input  logic        clr_valid,
  input  logic [31:0] clr_board,
  output logic [31:0] disp_board,
  output logic        game_over
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(GRAV_TICKS - 1);

  logic [2:0]         state;
  logic [2:0]         next_state;
  logic [BOARD_W-1:0] settled;
  logic [BOARD_W-1:0] active;
  logic [CNT_W-1:0]   counter;

  logic [BOARD_W-1:0] down_next;
  logic [BOARD_W-1:0] left_next;
  logic [BOARD_W-1:0] right_next;
  logic               down_blocked;
  logic               left_blocked;
  logic               right_blocked;
  logic               tick;
  logic [BOARD_W-1:0] new_mask;
  logic               spawn_hit;

  piece_mover u_mover (
    .active        (active),
    .settled       (settled),
    .down_next     (down_next),
    .left_next     (left_next),
    .right_next    (right_next),
    .down_blocked  (down_blocked),
    .left_blocked  (left_blocked),
    .right_blocked (right_blocked)
  );

  // Shared decode terms and the display view of the board.
  always_comb begin
    tick       = (counter == TICK_LAST) || drop_fast;
    new_mask   = spawn_mask(curr_piece);
    spawn_hit  = |(new_mask & settled);
    disp_board = settled | active;
  end

  // State register.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (start) next_state = ST_SPAWN;
      ST_SPAWN:    next_state = spawn_hit ? ST_GAMEOVER : ST_FALL;
      ST_FALL:     if (tick && down_blocked) next_state = ST_HANDOFF;
      ST_HANDOFF:  if (lock_valid && lock_ready) next_state = ST_WAIT_CLR;
      ST_WAIT_CLR: if (clr_valid) next_state = ST_SPAWN;
      ST_GAMEOVER: if (start) next_state = ST_SPAWN;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Board, piece, gravity counter and handshake registers.
  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      settled    <= '0;
      active     <= '0;
      lock_board <= '0;
      lock_valid <= 1'b0;
      game_over  <= 1'b0;
      counter    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_GAMEOVER: begin
          if (start) begin
            settled   <= '0;
            active    <= '0;
            game_over <= 1'b0;
          end
        end
        ST_SPAWN: begin
          // The piece is loaded even on overlap so the collision stays visible.
          active  <= new_mask;
          counter <= '0;
          if (spawn_hit) game_over <= 1'b1;
        end
        ST_FALL: begin
          if (tick) begin
            if (!down_blocked) begin
              active  <= down_next;
              counter <= '0;
            end else begin
              lock_board <= settled | active;
              active     <= '0;
              lock_valid <= 1'b1;
            end
          end else begin
            counter <= counter + CNT_W'(1);
            if (move_left && !move_right && !left_blocked)
              active <= left_next;
            else if (move_right && !move_left && !right_blocked)
              active <= right_next;
          end
        end
        ST_HANDOFF: begin
          if (lock_valid && lock_ready) lock_valid <= 1'b0;
        end
        ST_WAIT_CLR: begin
          if (clr_valid) settled <= clr_board;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piece_drop.sv
`default_nettype none
// ============================================================================
// Module      : tb_piece_drop
// Description : Directed self-checking bench for piece_drop.
// Revision    : 1.0  initial release
// ============================================================================
module tb_piece_drop;

  logic        clka = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  curr_piece;
  logic        move_left;
  logic        move_right;
  logic        drop_fast;
  logic        lock_valid;
  logic [31:0] lock_board;
  logic        lock_ready;
  logic        clr_valid;
  logic [31:0] clr_board;
  logic [31:0] disp_board;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  piece_drop #(.GRAV_TICKS(8), .CNT_W(8)) dut (
    .clka       (clka),
    .reset      (reset),
    .start      (start),
    .curr_piece (curr_piece),
    .move_left  (move_left),
    .move_right (move_right),
    .drop_fast  (drop_fast),
    .lock_valid (lock_valid),
    .lock_board (lock_board),
    .lock_ready (lock_ready),
    .clr_valid  (clr_valid),
    .clr_board  (clr_board),
    .disp_board (disp_board),
    .game_over  (game_over)
  );

  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; curr_piece = 2'b00;
    move_left = 1'b0; move_right = 1'b0; drop_fast = 1'b0;
    lock_ready = 1'b1; clr_valid = 1'b0; clr_board = '0;
    step(2);
    check("rst_lock_valid", {31'd0, lock_valid}, 32'd0);
    check("rst_lock_board", lock_board, 32'h0);
    check("rst_disp", disp_board, 32'h0);
    check("rst_game_over", {31'd0, game_over}, 32'd0);
    reset = 1'b0;

    // Square falls under normal gravity to the floor and locks.
    start = 1'b1; curr_piece = 2'b10;
    step(1);
    start = 1'b0;
    check("spawn_cycle_disp", disp_board, 32'h0);
    step(1);
    check("spawn_square", disp_board, 32'h0000_0066);
    step(7);
    check("grav_not_yet", disp_board, 32'h0000_0066);
    step(1);
    check("grav_row1", disp_board, 32'h0000_0660);
    step(40);
    check("square_floor", disp_board, 32'h6600_0000);
    check("no_lock_yet", {31'd0, lock_valid}, 32'd0);
    step(8);
    check("lock_valid_sq", {31'd0, lock_valid}, 32'd1);
    check("lock_board_sq", lock_board, 32'h6600_0000);
    check("handoff_disp", disp_board, 32'h0);
    step(1);
    check("xfer_sq", {31'd0, lock_valid}, 32'd0);
    clr_valid = 1'b1; clr_board = 32'h6600_0000; curr_piece = 2'b00;
    step(1);
    clr_valid = 1'b0;
    step(1);
    check("spawn_dot", disp_board, 32'h6600_0002);

    // Lateral moves against the walls.
    move_left = 1'b1;
    step(1);
    check("left_1", disp_board, 32'h6600_0001);
    step(2);
    check("left_wall", disp_board, 32'h6600_0001);
    move_left = 1'b0; move_right = 1'b1;
    step(1);
    check("right_1", disp_board, 32'h6600_0002);
    step(2);
    check("right_3", disp_board, 32'h6600_0008);
    step(1);
    check("right_wall", disp_board, 32'h6600_0008);
    move_right = 1'b0;
    step(1);
    check("dot_grav", disp_board, 32'h6600_0080);
    check("go_after_moves", {31'd0, game_over}, 32'd0);

    // Held handoff with lock_ready low.
    lock_ready = 1'b0; drop_fast = 1'b1;
    step(6);
    check("dot_bottom", disp_board, 32'hE600_0000);
    step(1);
    drop_fast = 1'b0;
    check("lock_valid_dot", {31'd0, lock_valid}, 32'd1);
    check("lock_board_dot", lock_board, 32'hE600_0000);
    step(10);
    check("hold_valid", {31'd0, lock_valid}, 32'd1);
    check("hold_board", lock_board, 32'hE600_0000);
    lock_ready = 1'b1;
    step(1);
    check("xfer_dot", {31'd0, lock_valid}, 32'd0);
    lock_ready = 1'b0;
    step(1);
    check("post_xfer_low", {31'd0, lock_valid}, 32'd0);

    // Empty board returned, fast-dropping L piece.
    clr_valid = 1'b1; clr_board = 32'h0; curr_piece = 2'b11; drop_fast = 1'b1;
    step(1);
    clr_valid = 1'b0;
    check("clr_empty", disp_board, 32'h0);
    step(1);
    check("spawn_l", disp_board, 32'h0000_0062);
    step(1);
    check("fast_row1", disp_board, 32'h0000_0620);
    step(5);
    check("fast_floor", disp_board, 32'h6200_0000);
    check("fast_no_lock", {31'd0, lock_valid}, 32'd0);
    step(1);
    drop_fast = 1'b0;
    check("fast_lock_valid", {31'd0, lock_valid}, 32'd1);
    check("fast_lock_board", lock_board, 32'h6200_0000);
    lock_ready = 1'b1;
    step(1);
    check("fast_xfer", {31'd0, lock_valid}, 32'd0);

    // Spawn onto occupied cells ends the game.
    clr_valid = 1'b1; clr_board = 32'h0000_0006; curr_piece = 2'b01;
    step(1);
    clr_valid = 1'b0;
    step(1);
    check("game_over_set", {31'd0, game_over}, 32'd1);
    check("go_disp", disp_board, 32'h0000_0006);
    move_left = 1'b1; drop_fast = 1'b1; clr_valid = 1'b1; clr_board = 32'h0;
    step(3);
    move_left = 1'b0; drop_fast = 1'b0; clr_valid = 1'b0;
    check("go_ignore_disp", disp_board, 32'h0000_0006);
    check("go_sticky", {31'd0, game_over}, 32'd1);
    check("go_no_lock", {31'd0, lock_valid}, 32'd0);
    start = 1'b1; curr_piece = 2'b10;
    step(1);
    start = 1'b0;
    check("restart_clear", disp_board, 32'h0);
    check("restart_go", {31'd0, game_over}, 32'd0);
    step(1);
    check("restart_spawn", disp_board, 32'h0000_0066);

    // Asynchronous reset in the middle of a handoff.
    lock_ready = 1'b0; drop_fast = 1'b1;
    step(7);
    drop_fast = 1'b0;
    check("pre_rst_valid", {31'd0, lock_valid}, 32'd1);
    check("pre_rst_board", lock_board, 32'h6600_0000);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", {31'd0, lock_valid}, 32'd0);
    check("async_board", lock_board, 32'h0);
    check("async_disp", disp_board, 32'h0);
    step(1);
    reset = 1'b0; curr_piece = 2'b00; lock_ready = 1'b1;
    step(5);
    check("idle_disp", disp_board, 32'h0);
    check("idle_valid", {31'd0, lock_valid}, 32'd0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check("post_rst_spawn", disp_board, 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piece_drop.md
Name: piece_drop

Overview:
- Active-piece engine that feeds the clear/redraw stage and takes its output back.
- Spawns the current piece at the top of the 4x8 board, applies gravity and left/right moves, detects landing, and merges the piece into the settled board.
- Offers the merged board downstream with a valid/ready handshake, then waits for the cleared board to return before spawning the next piece.
- Owns the settled-board register and the game-over flag.

Parameters:
GRAV_TICKS, 8, clka cycles in FALL between gravity steps (2..255)
CNT_W, 8, gravity counter width; must hold GRAV_TICKS-1

Ports:
clka  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: clear board, begin game (honoured in IDLE and GAMEOVER only)
curr_piece  in  2  piece code sampled in SPAWN
move_left  in  1  level; one column per FALL cycle while held
move_right  in  1  level; one column per FALL cycle while held
drop_fast  in  1  level; gravity tick every FALL cycle while high
lock_valid  out  1  merged board available on lock_board
lock_board  out  32  settled|piece at landing, stable while lock_valid
lock_ready  in  1  downstream accepts lock_board
clr_valid  in  1  single-cycle pulse: clr_board holds the cleared board
clr_board  in  32  board after row clear, without a new piece
disp_board  out  32  settled | active mask, combinational from registers
game_over  out  1  sticky; spawn overlapped settled cells

Behaviour:
- Board encoding:
  - Row r occupies bits [4r+3:4r]; row 0 ([3:0]) is the top and row 7 ([31:28]) the bottom.
  - Column c of row r is bit 4r+c.
- Spawn masks:
  - 00: bit 1.
  - 01: bits 1,2.
  - 10: bits 1,2,5,6.
  - 11: bits 1,5,6.
- Reset values:
  - state IDLE; settled, active, lock_board all 0.
  - lock_valid 0, game_over 0, gravity counter 0.
  - Reset is legal in any state and abandons any in-flight handshake.
- FSM states: IDLE, SPAWN, FALL, HANDOFF, WAIT_CLR, GAMEOVER.
- IDLE:
  - On start: settled<=0, game_over<=0, go to SPAWN.
- SPAWN (exactly 1 cycle):
  - active<=mask(curr_piece); counter<=0.
  - If mask & settled != 0: game_over<=1 and go to GAMEOVER (active still loaded so the overlap is visible).
  - Otherwise go to FALL.
  - The piece is visible on disp_board 2 cycles after start is sampled.
- FALL, one action per cycle, checked in priority order:
  1. Gravity tick: (counter==GRAV_TICKS-1) or drop_fast.
     - Down is blocked if active[31:28]!=0 or (active<<4)&settled!=0.
     - Not blocked: active<<=4, counter<=0.
     - Blocked: lock_board<=settled|active, active<=0, settled unchanged, lock_valid<=1, go to HANDOFF.
  2. Else move_left xor move_right:
     - Left is blocked if active&32'h1111_1111 or (active>>1)&settled; otherwise active>>=1.
     - Right is blocked if active&32'h8888_8888 or (active<<1)&settled; otherwise active<<=1.
     - A blocked move is a no-op.
  3. Both moves high: ignored.
  - Counter increments every FALL cycle that has no tick.
- HANDOFF:
  - lock_valid stays high and lock_board stays stable.
  - Transfer occurs on the cycle lock_valid&&lock_ready: lock_valid<=0, go to WAIT_CLR.
- WAIT_CLR:
  - On clr_valid: settled<=clr_board, go to SPAWN.
  - clr_valid in any other state is ignored.
- GAMEOVER:
  - Inputs ignored except start, which behaves as in IDLE (board cleared, new spawn).
  - disp_board keeps showing the board until start.
- disp_board = settled|active in every state.
- The active mask never leaves the board; no wrap between rows, guaranteed by the column checks.

Decomposition:
- Shared package tetris_pkg:
  - BOARD_W=32, ROW_W=4, NUM_ROWS=8.
  - Piece code localparams PIECE_DOT/DOMINO/SQUARE/L.
  - COL0_MASK=32'h1111_1111, COL3_MASK=32'h8888_8888, BOTTOM_ROW_MASK=32'hF000_0000.
  - State encoding.
- One sub-module piece_mover: purely combinational.
  - Inputs: active, settled.
  - Outputs: next masks for down/left/right plus three blocked flags.
  - Keeps collision logic separate from the FSM.

Test Plan:
1. Reset, start, curr_piece=10, lock_ready=1, no moves.
   - Spawn gives disp_board=32'h0000_0066.
   - After 6 gravity periods, active=32'h6600_0000.
   - On the 7th tick, lock_valid=1 with lock_board=32'h6600_0000.
2. curr_piece=00, hold move_left 3 cycles, then move_right 5 cycles.
   - Active goes bit1 -> bit0 and holds there, then walks right to bit3 and holds there; game_over stays 0.
3. HANDOFF with lock_ready=0 for 10 cycles.
   - lock_valid and lock_board stay stable.
   - Raising lock_ready gives a single-cycle transfer, then WAIT_CLR.
   - clr_valid with clr_board=32'h0000_0000 leads to SPAWN.
4. Return clr_board=32'h0000_0006, then spawn curr_piece=01.
   - game_over=1, state GAMEOVER, disp_board=32'h0000_0006; moves ignored.
   - start clears the board and respawns.
5. drop_fast=1 with curr_piece=11.
   - Piece descends one row per cycle and reaches rows 6-7 in 6 cycles.
   - lock_valid rises on the 7th FALL cycle.
6. Assert reset during HANDOFF.
   - lock_valid=0 and all registers 0 immediately, asynchronously.
   - After release the block stays in IDLE until start.
